serial_cmp_accum: RTL and testbench



---
 rtl/serial_cmp_accum.sv | 138 +++++++++++++
 tb/tb_serial_cmp_accum.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmp_accum.sv
// Serial magnitude accumulator: folds MSB-first 1-bit compare flags into a word result.
// Optional sticky one-hot flag check enabled by SERIAL_CMP_ONEHOT_CHECK_EN.
module serial_cmp_accum #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_first,
    input  logic greater,
    input  logic equal,
    input  logic lower,
    output logic busy,
    output logic out_valid,
    output logic out_gt,
    output logic out_eq,
    output logic out_lt,
    output logic err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, ACCUM} state_t;
    typedef enum logic [1:0] {RES_EQ = 2'd0, RES_GT = 2'd1, RES_LT = 2'd2} res_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          decided_q, decided_d;
    res_t          res_q, res_d;
    logic          fin;
    logic          hit;
    res_t          flag;

    // Priority decode of the flag triple: greater beats lower beats equal.
    always_comb begin
        hit  = greater | lower;
        flag = RES_EQ;
        if (greater) begin
            flag = RES_GT;
        end else if (lower) begin
            flag = RES_LT;
        end
    end

    // Next-state and datapath update for one accepted beat.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        res_d     = res_q;
        fin       = 1'b0;
        if (in_valid) begin
            if (in_first) begin
                cnt_d     = CW'(1);
                decided_d = hit;
                res_d     = flag;
                if (WIDTH == 1) begin
                    fin     = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = ACCUM;
                end
            end else if (state_q == ACCUM) begin
                cnt_d = cnt_q + CW'(1);
                if (!decided_q && hit) begin
                    decided_d = 1'b1;
                    res_d     = flag;
                end
                if (cnt_q + CW'(1) == CW'(WIDTH)) begin
                    fin     = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Accumulator registers and the registered result strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            decided_q <= 1'b0;
            res_q     <= RES_EQ;
            out_valid <= 1'b0;
            out_gt    <= 1'b0;
            out_eq    <= 1'b0;
            out_lt    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            res_q     <= res_d;
            out_valid <= fin;
            if (fin) begin
                out_gt <= (res_d == RES_GT);
                out_eq <= (res_d == RES_EQ);
                out_lt <= (res_d == RES_LT);
            end
        end
    end

    assign busy = (state_q == ACCUM);

`ifdef SERIAL_CMP_ONEHOT_CHECK_EN
    logic onehot;
    logic err_q;

    assign onehot = ({greater, equal, lower} == 3'b100) |
                    ({greater, equal, lower} == 3'b010) |
                    ({greater, equal, lower} == 3'b001);

    // Sticky flag for any accepted beat whose triple is not one-hot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (in_valid && !onehot) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_equal;

    assign unused_equal = equal;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_serial_cmp_accum.sv
// Bench for serial_cmp_accum: directed plan plus random words vs. an integer-compare model.
// Expected err follows SERIAL_CMP_ONEHOT_CHECK_EN.
module tb_serial_cmp_accum;

    localparam int W = 4;
    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_first, greater, equal, lower;
    logic busy, out_valid, out_gt, out_eq, out_lt, err;
    logic v1, f1, g1, e1, l1;
    logic busy1, ov1, gt1, eq1, lt1, err1;

    int checks = 0;
    int errors = 0;
    logic [2:0] last_exp;
    logic err_exp;

    always #5 clk = ~clk;

    serial_cmp_accum #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
        .greater(greater), .equal(equal), .lower(lower),
        .busy(busy), .out_valid(out_valid), .out_gt(out_gt),
        .out_eq(out_eq), .out_lt(out_lt), .err(err)
    );

    serial_cmp_accum #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_first(f1),
        .greater(g1), .equal(e1), .lower(l1),
        .busy(busy1), .out_valid(ov1), .out_gt(gt1),
        .out_eq(eq1), .out_lt(lt1), .err(err1)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Reference rule: first bit with greater or lower set decides, greater first.
    function automatic logic [2:0] model(input logic [11:0] w);
        for (int i = 0; i < W; i++) begin
            if (w[11-3*i]) return GT;
            if (w[9-3*i]) return LT;
        end
        return EQ;
    endfunction

    function automatic logic is_onehot(input logic [2:0] c);
        return (c == GT) || (c == EQ) || (c == LT);
    endfunction

    task automatic note_beat(input logic [2:0] c);
`ifdef SERIAL_CMP_ONEHOT_CHECK_EN
        if (!is_onehot(c)) err_exp = 1'b1;
`else
        if (!is_onehot(c)) err_exp = 1'b0;
`endif
    endtask

    task automatic chk_res(input string tag);
        chk({tag, "_gt"}, out_gt, last_exp[2]);
        chk({tag, "_eq"}, out_eq, last_exp[1]);
        chk({tag, "_lt"}, out_lt, last_exp[0]);
    endtask

    // Drives one word; returns at the strobe cycle with in_valid still high.
    task automatic send_word(input logic [11:0] w, input logic [2:0] exp,
                             input int gap);
        for (int i = 0; i < W; i++) begin
            in_valid = 1'b1;
            in_first = (i == 0);
            {greater, equal, lower} = w[11-3*i -: 3];
            note_beat(w[11-3*i -: 3]);
            @(negedge clk);
            if (i < W - 1) begin
                chk("word_busy", busy, 1'b1);
                chk("word_nostrobe", out_valid, 1'b0);
            end
            if (i == 1 && gap > 0) begin
                in_valid = 1'b0;
                in_first = 1'b0;
                repeat (gap) begin
                    @(negedge clk);
                    chk("gap_busy", busy, 1'b1);
                    chk("gap_nostrobe", out_valid, 1'b0);
                end
            end
        end
        last_exp = exp;
        chk("strobe", out_valid, 1'b1);
        chk("done_busy", busy, 1'b0);
        chk_res("res");
        chk("err", err, err_exp);
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        in_first = 1'b0;
        {greater, equal, lower} = 3'b000;
        repeat (n) begin
            @(negedge clk);
            chk("idle_nostrobe", out_valid, 1'b0);
            chk_res("hold");
        end
    endtask

    initial begin
        logic [11:0] w;
        logic [3:0] a, b;
        rst = 1'b1;
        in_valid = 1'b0; in_first = 1'b0;
        {greater, equal, lower} = 3'b000;
        v1 = 1'b0; f1 = 1'b0; {g1, e1, l1} = 3'b000;
        last_exp = 3'b000;
        err_exp = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk_res("rst");
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Ignored non-first beat while idle.
        in_valid = 1'b1; in_first = 1'b0; {greater, equal, lower} = GT;
        @(negedge clk);
        chk("idle_ignore_busy", busy, 1'b0);
        idle_cycles(1);

        send_word({EQ, EQ, GT, LT}, GT, 0);
        idle_cycles(2);
        send_word({EQ, EQ, EQ, EQ}, EQ, 0);
        idle_cycles(1);
        send_word({LT, GT, GT, GT}, LT, 0);
        idle_cycles(1);

        // Abort after two beats, restart with a fresh first beat.
        in_valid = 1'b1; in_first = 1'b1; {greater, equal, lower} = EQ;
        @(negedge clk);
        in_first = 1'b0; {greater, equal, lower} = GT;
        @(negedge clk);
        chk("abort_busy", busy, 1'b1);
        send_word({EQ, EQ, EQ, EQ}, EQ, 0);
        idle_cycles(2);

        // Gapped word followed immediately by the next word.
        send_word({GT, LT, EQ, EQ}, GT, 3);
        send_word({EQ, LT, EQ, GT}, LT, 0);
        idle_cycles(1);

        // Random legal words against an integer comparison.
        for (int k = 0; k < 16; k++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            for (int i = 0; i < W; i++)
                w[11-3*i -: 3] = (a[3-i] > b[3-i]) ? GT :
                                 (a[3-i] < b[3-i]) ? LT : EQ;
            send_word(w, {a > b, a == b, a < b}, int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 0) idle_cycles(1);
        end
        idle_cycles(1);

        // Reset mid-word clears everything asynchronously.
        in_valid = 1'b1; in_first = 1'b1; {greater, equal, lower} = GT;
        @(negedge clk);
        in_first = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_valid", out_valid, 1'b0);
        last_exp = 3'b000;
        chk_res("arst");
        @(negedge clk);
        rst = 1'b0;
        send_word({EQ, LT, GT, EQ}, LT, 0);
        idle_cycles(1);

        // Non-one-hot triples: priority decode and sticky err.
        send_word({3'b101, EQ, LT, EQ}, GT, 0);
        idle_cycles(1);
        send_word({3'b000, 3'b011, EQ, EQ}, LT, 0);
        idle_cycles(1);
        send_word({3'b000, EQ, 3'b000, EQ}, EQ, 0);
        idle_cycles(1);
        for (int k = 0; k < 8; k++) begin
            w = 12'($urandom);
            send_word(w, model(w), 0);
        end
        idle_cycles(1);
        rst = 1'b1;
        #1;
        err_exp = 1'b0;
        chk("err_clear", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        last_exp = 3'b000;

        // Single-bit instance finishes on its first beat.
        v1 = 1'b1; f1 = 1'b1; {g1, e1, l1} = GT;
        @(negedge clk);
        chk("w1_strobe", ov1, 1'b1);
        chk("w1_gt", gt1, 1'b1);
        chk("w1_busy", busy1, 1'b0);
        {g1, e1, l1} = LT;
        @(negedge clk);
        chk("w1_strobe2", ov1, 1'b1);
        chk("w1_lt", lt1, 1'b1);
        chk("w1_gt2", gt1, 1'b0);
        v1 = 1'b0;
        @(negedge clk);
        chk("w1_nostrobe", ov1, 1'b0);
        chk("w1_hold", lt1, 1'b1);
        chk("w1_err", err1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
